// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 interrupt path.
//   irq_state_e   : controller FSM states
//   CFG_*         : configuration register addresses
//   STAT_*        : bit positions inside the STATUS register
//   irq_vector()  : vector address of an IRQ source
package cpu_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_e;

   localparam logic [1:0] CFG_MASK    = 2'd0;
   localparam logic [1:0] CFG_MODE    = 2'd1;
   localparam logic [1:0] CFG_PENDING = 2'd2;
   localparam logic [1:0] CFG_STATUS  = 2'd3;

   localparam int STAT_ISR_NMI  = 7;
   localparam int STAT_ISR_IRQ  = 6;
   localparam int STAT_NMI_PEND = 5;
   localparam int STAT_ID_MSB   = 2;

   // Each vector table entry is a 16-bit pointer, hence the 2*id spacing.
   function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [2:0] id);
      return base + {12'd0, id, 1'b0};
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus between control_unit (master) and irq_controller (slave).
//   src_in/nmi_in       : raw interrupt lines
//   i_flag              : CPU I flag, blocks IRQ only
//   int_ack/eoi         : vector-fetch start and RTI pulses
//   cfg_we/addr/wdata   : configuration write port, cfg_rdata combinational read
//   irq_req/nmi_req     : requests to the CPU
//   vector_addr/int_id  : vector and source id of the current/serviced request
interface irq_controller_if #(
   parameter int NUM_SRC = 8
);
   logic [NUM_SRC-1:0] src_in;
   logic               nmi_in;
   logic               i_flag;
   logic               int_ack;
   logic               eoi;
   logic               cfg_we;
   logic [1:0]         cfg_addr;
   logic [7:0]         cfg_wdata;
   logic [7:0]         cfg_rdata;
   logic               irq_req;
   logic               nmi_req;
   logic [15:0]        vector_addr;
   logic [2:0]         int_id;

   modport master (
      output src_in, nmi_in, i_flag, int_ack, eoi, cfg_we, cfg_addr, cfg_wdata,
      input  cfg_rdata, irq_req, nmi_req, vector_addr, int_id
   );

   modport slave (
      input  src_in, nmi_in, i_flag, int_ack, eoi, cfg_we, cfg_addr, cfg_wdata,
      output cfg_rdata, irq_req, nmi_req, vector_addr, int_id
   );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous line plus a rising-edge pulse.
//   clk, rst  : clock, asynchronous active-low reset
//   async_i   : raw asynchronous input
//   level_o   : synchronised level (last synchroniser stage)
//   rise_o    : one-cycle pulse when level_o goes 0 -> 1
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller for the 6502 core.
// Synchronises NUM_SRC IRQ lines and one NMI, latches edge/level requests,
// applies mask and fixed priority (id 0 highest) and hands one request at a
// time to control_unit, tracking in-service state until RTI (eoi).
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : irq_controller_if.slave (lines, handshake, config port, requests)
module irq_controller
   import cpu_pkg::*;
#(
   parameter int          NUM_SRC     = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] VEC_BASE    = 16'hFFE0,
   parameter logic [15:0] NMI_VEC     = 16'hFFFA
) (
   input logic              clk,
   input logic              rst,
   irq_controller_if.slave  bus
);

   localparam int N = NUM_SRC;

   logic [N-1:0] src_lvl, src_rise;
   logic         nmi_lvl, nmi_rise;
   logic         unused_nmi_lvl;

   for (genvar g = 0; g < N; g++) begin : g_src_sync
      sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk     (clk),
         .rst     (rst),
         .async_i (bus.src_in[g]),
         .level_o (src_lvl[g]),
         .rise_o  (src_rise[g])
      );
   end

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.nmi_in),
      .level_o (nmi_lvl),
      .rise_o  (nmi_rise)
   );

   // NMI is purely edge-triggered; its level is not needed.
   assign unused_nmi_lvl = nmi_lvl;

   // Configuration and request state
   logic [N-1:0] mask_q, mask_d;
   logic [N-1:0] mode_q, mode_d;
   logic [N-1:0] pend_q, pend_d;
   logic         nmi_pend_q, nmi_pend_d;

   // FSM state
   irq_state_e   state_q, state_d;
   logic         kind_nmi_q, kind_nmi_d;
   logic [2:0]   id_q, id_d;
   logic [15:0]  vec_q, vec_d;
   logic         isr_nmi_q, isr_nmi_d;
   logic         isr_irq_q, isr_irq_d;

   logic         ack_irq, ack_nmi;
   logic [N-1:0] wdata_n, w1c, eligible, id_onehot;
   logic         win_any, id_eligible;
   logic [2:0]   win_id;

   assign wdata_n  = bus.cfg_wdata[N-1:0];
   assign w1c      = (bus.cfg_we && bus.cfg_addr == CFG_PENDING) ? wdata_n : '0;
   assign eligible = pend_q & mask_q;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         id_onehot[i] = (id_q == 3'(i));
      end
   end

   assign id_eligible = |(eligible & id_onehot);

   // Fixed priority: scan downwards so the lowest set index is left last.
   always_comb begin
      win_any = 1'b0;
      win_id  = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_any = 1'b1;
            win_id  = 3'(i);
         end
      end
   end

   // Config registers and pending latches.
   // Edge mode: a new edge beats a same-cycle W1C or ack clear.
   // Level mode: PENDING simply follows the synchronised line.
   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      if (bus.cfg_we && bus.cfg_addr == CFG_MASK) mask_d = wdata_n;
      if (bus.cfg_we && bus.cfg_addr == CFG_MODE) mode_d = wdata_n;

      for (int i = 0; i < N; i++) begin
         if (mode_q[i]) begin
            pend_d[i] = src_rise[i] |
                        (pend_q[i] & ~w1c[i] & ~(ack_irq & id_onehot[i]));
         end else begin
            pend_d[i] = src_lvl[i];
         end
      end

      nmi_pend_d = nmi_rise | (nmi_pend_q & ~ack_nmi);
   end

   // FSM next state
   always_comb begin
      state_d    = state_q;
      kind_nmi_d = kind_nmi_q;
      id_d       = id_q;
      vec_d      = vec_q;
      isr_nmi_d  = isr_nmi_q;
      isr_irq_d  = isr_irq_q;
      ack_irq    = 1'b0;
      ack_nmi    = 1'b0;

      case (state_q)
         IRQ_IDLE: begin
            if (nmi_pend_q) begin
               state_d    = IRQ_REQ;
               kind_nmi_d = 1'b1;
               vec_d      = NMI_VEC;
            end else if (win_any && !bus.i_flag && !isr_irq_q) begin
               state_d    = IRQ_REQ;
               kind_nmi_d = 1'b0;
               id_d       = win_id;
               vec_d      = irq_vector(VEC_BASE, win_id);
            end
         end

         IRQ_REQ: begin
            // Ack has priority: once seen, the request is committed.
            if (bus.int_ack) begin
               state_d = IRQ_SERVICE;
               if (kind_nmi_q) begin
                  isr_nmi_d = 1'b1;
                  ack_nmi   = 1'b1;
               end else begin
                  isr_irq_d = 1'b1;
                  ack_irq   = 1'b1;
               end
            end else if (!kind_nmi_q && (bus.i_flag || !id_eligible)) begin
               state_d = IRQ_IDLE;
            end
         end

         IRQ_SERVICE: begin
            // RTI retires the most recently entered level first.
            if (bus.eoi) begin
               if (isr_nmi_q) isr_nmi_d = 1'b0;
               else           isr_irq_d = 1'b0;
            end
            if (!isr_nmi_d && !isr_irq_d) begin
               state_d = IRQ_IDLE;
            end else if (nmi_pend_q && !isr_nmi_d) begin
               // NMI preempts a serviced IRQ; the IRQ id is kept in id_q.
               state_d    = IRQ_REQ;
               kind_nmi_d = 1'b1;
               vec_d      = NMI_VEC;
            end
         end

         default: state_d = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q     <= '0;
         mode_q     <= '0;
         pend_q     <= '0;
         nmi_pend_q <= 1'b0;
         state_q    <= IRQ_IDLE;
         kind_nmi_q <= 1'b0;
         id_q       <= 3'd0;
         vec_q      <= 16'd0;
         isr_nmi_q  <= 1'b0;
         isr_irq_q  <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         pend_q     <= pend_d;
         nmi_pend_q <= nmi_pend_d;
         state_q    <= state_d;
         kind_nmi_q <= kind_nmi_d;
         id_q       <= id_d;
         vec_q      <= vec_d;
         isr_nmi_q  <= isr_nmi_d;
         isr_irq_q  <= isr_irq_d;
      end
   end

   assign bus.irq_req     = (state_q == IRQ_REQ) && !kind_nmi_q;
   assign bus.nmi_req     = (state_q == IRQ_REQ) &&  kind_nmi_q;
   assign bus.vector_addr = vec_q;
   assign bus.int_id      = id_q;

   always_comb begin
      logic [7:0] status;
      status                 = 8'd0;
      status[STAT_ISR_NMI]   = isr_nmi_q;
      status[STAT_ISR_IRQ]   = isr_irq_q;
      status[STAT_NMI_PEND]  = nmi_pend_q;
      status[STAT_ID_MSB:0]  = id_q;

      case (bus.cfg_addr)
         CFG_MASK:    bus.cfg_rdata = 8'(mask_q);
         CFG_MODE:    bus.cfg_rdata = 8'(mode_q);
         CFG_PENDING: bus.cfg_rdata = 8'(pend_q);
         default:     bus.cfg_rdata = status;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
   import cpu_pkg::*;

   localparam int          NUM_SRC  = 8;
   localparam logic [15:0] VEC_BASE = 16'hFFE0;
   localparam logic [15:0] NMI_VEC  = 16'hFFFA;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   irq_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

   irq_controller #(
      .NUM_SRC(NUM_SRC), .SYNC_STAGES(2), .VEC_BASE(VEC_BASE), .NMI_VEC(NMI_VEC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          nmi;
      logic [15:0] vec;
      logic [2:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [2:0] model_id = 3'd0;   // int_id the controller should report

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      bus.cfg_we    = 1'b1;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] addr, output logic [7:0] data);
      bus.cfg_addr = addr;
      #1;
      data = bus.cfg_rdata;
   endtask

   task automatic push_irq(input int id);
      exp_t e;
      e.nmi = 1'b0;
      e.vec = VEC_BASE + 16'(2 * id);
      e.id  = 3'(id);
      model_id = 3'(id);
      exp_q.push_back(e);
   endtask

   task automatic push_nmi();
      exp_t e;
      e.nmi = 1'b1;
      e.vec = NMI_VEC;
      e.id  = model_id;
      exp_q.push_back(e);
   endtask

   task automatic wait_req(input string name);
      bit found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.irq_req || bus.nmi_req) begin
            found = 1'b1;
            break;
         end
      end
      check({name, "_req_seen"}, 32'(found), 32'd1);
   endtask

   task automatic do_ack();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   task automatic do_eoi();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
   endtask

   // Monitor: every new request popped against the scoreboard.
   logic mon_prev = 1'b0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_prev = 1'b0;
         end else begin
            if ((bus.irq_req || bus.nmi_req) && !mon_prev) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_req: got irq=%0b nmi=%0b vec=%0h required no request",
                           bus.irq_req, bus.nmi_req, bus.vector_addr);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("req_nmi",    32'(bus.nmi_req),     32'(mon_e.nmi));
                  check("req_irq",    32'(bus.irq_req),     32'(!mon_e.nmi));
                  check("req_vector", 32'(bus.vector_addr), 32'(mon_e.vec));
                  check("req_int_id", 32'(bus.int_id),      32'(mon_e.id));
               end
            end
            mon_prev = bus.irq_req || bus.nmi_req;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic [7:0] srcs, msk, pend;
      bit         do_nmi;
      int         id;

      bus.src_in    = '1;
      bus.nmi_in    = 1'b1;
      bus.i_flag    = 1'b1;
      bus.int_ack   = 1'b0;
      bus.eoi       = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = CFG_MASK;
      bus.cfg_wdata = 8'd0;

      // 1: reset held with every line active
      repeat (4) tick();
      check("rst_irq_req", 32'(bus.irq_req),     32'd0);
      check("rst_nmi_req", 32'(bus.nmi_req),     32'd0);
      check("rst_vector",  32'(bus.vector_addr), 32'd0);
      check("rst_int_id",  32'(bus.int_id),      32'd0);
      cfg_read(CFG_MASK, rd);   check("rst_mask",   32'(rd), 32'h00);
      cfg_read(CFG_STATUS, rd); check("rst_status", 32'(rd), 32'h00);
      bus.src_in = '0;
      bus.nmi_in = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();

      // 2: two edges together, lowest id wins, 4-clock latency
      cfg_write(CFG_MASK, 8'hFF);
      cfg_write(CFG_MODE, 8'hFF);
      bus.i_flag = 1'b0;
      push_irq(2);
      push_irq(5);
      bus.src_in = 8'h24;
      repeat (3) tick();
      check("latency_3clk_low", 32'(bus.irq_req), 32'd0);
      tick();
      check("latency_4clk_high", 32'(bus.irq_req), 32'd1);
      do_ack();
      do_eoi();
      bus.src_in = '0;
      wait_req("second_src5");
      do_ack();
      do_eoi();

      // 3: level source gated by I flag, then withdrawn
      cfg_write(CFG_MASK, 8'h08);
      cfg_write(CFG_MODE, 8'h00);
      bus.i_flag = 1'b1;
      bus.src_in = 8'h08;
      repeat (8) tick();
      check("iflag_blocks", 32'(bus.irq_req), 32'd0);
      cfg_read(CFG_PENDING, rd); check("level_pending", 32'(rd), 32'h08);
      push_irq(3);
      bus.i_flag = 1'b0;
      wait_req("level_src3");
      check("level_vector", 32'(bus.vector_addr), 32'hFFE6);
      bus.src_in = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!bus.irq_req) break;
      end
      check("withdraw_irq_req", 32'(bus.irq_req), 32'd0);
      cfg_read(CFG_STATUS, rd); check("withdraw_isr", 32'(rd & 8'hC0), 32'h00);
      tick();

      // 4: NMI preempts serviced IRQ 1
      cfg_write(CFG_MASK, 8'hFF);
      cfg_write(CFG_MODE, 8'hFF);
      push_irq(1);
      bus.src_in = 8'h02;
      wait_req("irq1");
      do_ack();
      bus.src_in = '0;
      cfg_read(CFG_STATUS, rd); check("svc_irq_status", 32'(rd), 32'h41);
      push_nmi();
      bus.nmi_in = 1'b1;
      wait_req("nmi_preempt");
      check("nmi_vector", 32'(bus.vector_addr), 32'hFFFA);
      do_ack();
      bus.nmi_in = 1'b0;
      cfg_read(CFG_STATUS, rd); check("nested_status", 32'(rd), 32'hC1);
      do_eoi();
      cfg_read(CFG_STATUS, rd); check("eoi1_status", 32'(rd), 32'h41);
      do_eoi();
      cfg_read(CFG_STATUS, rd); check("eoi2_status", 32'(rd), 32'h01);
      tick();

      // 5: W1C versus a coincident edge, and level-mode W1C
      cfg_write(CFG_MASK, 8'h00);
      cfg_write(CFG_MODE, 8'h01);
      bus.src_in = 8'h01;
      tick();
      tick();
      bus.cfg_addr  = CFG_PENDING;
      bus.cfg_wdata = 8'h01;
      bus.cfg_we    = 1'b1;
      tick();
      bus.cfg_we    = 1'b0;
      cfg_read(CFG_PENDING, rd); check("set_beats_w1c", 32'(rd), 32'h01);
      cfg_write(CFG_PENDING, 8'h01);
      cfg_read(CFG_PENDING, rd); check("w1c_clears", 32'(rd), 32'h00);
      bus.src_in = 8'h11;
      repeat (4) tick();
      cfg_write(CFG_PENDING, 8'h10);
      cfg_read(CFG_PENDING, rd); check("level_ignores_w1c", 32'(rd & 8'h10), 32'h10);
      bus.src_in = '0;
      repeat (4) tick();
      cfg_write(CFG_PENDING, 8'hFF);
      cfg_read(CFG_PENDING, rd); check("pending_idle", 32'(rd), 32'h00);

      // 6: reset while a request is being acknowledged
      cfg_write(CFG_MASK, 8'hFF);
      cfg_write(CFG_MODE, 8'hFF);
      push_irq(6);
      bus.src_in = 8'h40;
      wait_req("irq6");
      bus.int_ack = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("async_rst_irq_req", 32'(bus.irq_req),     32'd0);
      check("async_rst_vector",  32'(bus.vector_addr), 32'd0);
      check("async_rst_int_id",  32'(bus.int_id),      32'd0);
      model_id    = 3'd0;
      bus.int_ack = 1'b0;
      bus.src_in  = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      cfg_read(CFG_MASK, rd); check("post_rst_mask", 32'(rd), 32'h00);
      cfg_write(CFG_MASK, 8'hFF);
      cfg_write(CFG_MODE, 8'hFF);
      repeat (10) tick();
      check("post_rst_no_req", 32'(bus.irq_req | bus.nmi_req), 32'd0);
      cfg_read(CFG_PENDING, rd); check("post_rst_pending", 32'(rd), 32'h00);
      push_irq(1);
      bus.src_in = 8'h02;
      wait_req("post_rst_new_edge");
      do_ack();
      do_eoi();
      bus.src_in = '0;
      tick();

      // Randomised bursts of edges against the priority model
      cfg_write(CFG_MODE, 8'hFF);
      for (int it = 0; it < 20; it++) begin
         msk    = 8'($urandom_range(1, 255));
         srcs   = 8'($urandom_range(1, 255));
         do_nmi = ($urandom_range(0, 3) == 0);
         cfg_write(CFG_MASK, msk);
         bus.i_flag = 1'b1;
         if (do_nmi) push_nmi();
         bus.src_in = srcs;
         bus.nmi_in = do_nmi;
         repeat (5) tick();
         bus.src_in = '0;
         bus.nmi_in = 1'b0;
         if (do_nmi) begin
            wait_req("rand_nmi");
            do_ack();
            do_eoi();
         end
         pend = srcs;
         cfg_read(CFG_PENDING, rd); check("rand_pending", 32'(rd), 32'(pend));
         while ((pend & msk) != 8'd0) begin
            id = 0;
            while (!((pend & msk) & (8'd1 << id))) id++;
            push_irq(id);
            bus.i_flag = 1'b0;
            wait_req("rand_irq");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_ack();
            do_eoi();
            pend = pend & ~(8'd1 << id);
         end
         bus.i_flag = 1'b1;
         cfg_read(CFG_PENDING, rd); check("rand_leftover", 32'(rd), 32'(pend));
         cfg_write(CFG_PENDING, 8'hFF);
         cfg_read(CFG_PENDING, rd); check("rand_w1c_all", 32'(rd), 32'h00);
      end

      repeat (5) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
